// File: rtl/microwave_timer_ctrl.sv
// Microwave timer control: keypad entry register, parallel-load strobe and
// count-enable gating for the four-digit BCD countdown chain, and the
// idle / run / pause / alarm sequencer that drives the magnetron and buzzer.
module microwave_timer_ctrl #(
    parameter int BEEP_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       tick_1hz,
    input  logic       time_zero,
    output logic [3:0] in3,
    output logic [3:0] in2,
    output logic [3:0] in1,
    output logic [3:0] in0,
    output logic       load,
    output logic       enablen,
    output logic       cooking,
    output logic       alarm,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS);

    state_t      state_q, state_d;
    logic [15:0] entry_q, entry_d;
    logic        load_q, load_d;
    logic [3:0]  beep_q, beep_d;

    logic        entry_nonzero;
    logic        key_digit;
    logic        run_tick;
    logic [3:0]  beep_inc;

    assign entry_nonzero = |entry_q;
    assign key_digit     = key_valid && (key_code <= 4'd9);
    assign beep_inc      = beep_q + 4'd1;

    // A tick counts in RUN only when Stop is not pressed and the counters are not loading.
    assign run_tick = (state_q == RUN) && tick_1hz && !stop_clear && !load_q;

    // State, entry digits, load strobe and beep counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            entry_q <= 16'h0000;
            load_q  <= 1'b0;
            beep_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            load_q  <= load_d;
            beep_q  <= beep_d;
        end
    end

    // Next-state sequencing with stop_clear > start > key_valid priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!stop_clear && start && entry_nonzero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop_clear) begin
                    state_d = PAUSE;
                end else if (run_tick && time_zero) begin
                    state_d = ALARM;
                end
            end
            PAUSE: begin
                if (stop_clear) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            ALARM: begin
                if (stop_clear) begin
                    state_d = IDLE;
                end else if (tick_1hz && (beep_inc == BEEP_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry shift/clear, load strobe requests and beep counting.
    always_comb begin
        entry_d = entry_q;
        load_d  = 1'b0;
        beep_d  = beep_q;
        case (state_q)
            IDLE: begin
                if (stop_clear) begin
                    entry_d = 16'h0000;
                end else if (start) begin
                    load_d = entry_nonzero;
                end else if (key_digit) begin
                    entry_d = {entry_q[11:0], key_code};
                end
            end
            RUN: begin
                if (run_tick && time_zero) begin
                    beep_d = 4'd0;
                end
            end
            PAUSE: begin
                if (stop_clear) begin
                    entry_d = 16'h0000;
                    load_d  = 1'b1;
                end
            end
            ALARM: begin
                if (stop_clear) begin
                    entry_d = 16'h0000;
                end else if (tick_1hz) begin
                    beep_d = beep_inc;
                    if (beep_inc == BEEP_LAST) begin
                        entry_d = 16'h0000;
                    end
                end
            end
            default: begin
                entry_d = 16'h0000;
            end
        endcase
    end

    // Moore status outputs plus the combinational count enable for the chain.
    always_comb begin
        cooking = (state_q == RUN);
        alarm   = (state_q == ALARM);
        busy    = (state_q != IDLE);
        enablen = !(run_tick && !time_zero);
    end

    assign load = load_q;
    assign in3  = entry_q[15:12];
    assign in2  = entry_q[11:8];
    assign in1  = entry_q[7:4];
    assign in0  = entry_q[3:0];

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Testbench for microwave_timer_ctrl: a behavioural BCD countdown chain
// supplies time_zero, and a scoreboard of expected output vectors is
// filled as each cycle's stimulus is driven and drained at the falling edge.
module tb_microwave_timer_ctrl;

    localparam int BEEP = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       start = 1'b0;
    logic       stop_clear = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       time_zero;
    logic [3:0] in3, in2, in1, in0;
    logic       load, enablen, cooking, alarm, busy;

    int checkCount = 0;
    int failCount  = 0;

    logic [15:0] eD = 16'h0;
    logic        eLoad = 1'b0;
    logic        eEn = 1'b1;
    logic        eCook = 1'b0;
    logic        eAlarm = 1'b0;
    logic        eBusy = 1'b0;

    logic [31:0] expQ[$];
    string       tagQ[$];

    logic [15:0] cnt = 16'h0;

    microwave_timer_ctrl #(.BEEP_TICKS(BEEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .start      (start),
        .stop_clear (stop_clear),
        .tick_1hz   (tick_1hz),
        .time_zero  (time_zero),
        .in3        (in3),
        .in2        (in2),
        .in1        (in1),
        .in0        (in0),
        .load       (load),
        .enablen    (enablen),
        .cooking    (cooking),
        .alarm      (alarm),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One BCD decrement of mm:ss, seconds tens wrapping to 5 on borrow.
    function automatic logic [15:0] bcdDec(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        m1 = v[15:12]; m0 = v[11:8]; s1 = v[7:4]; s0 = v[3:0];
        if (s0 != 4'd0) s0 = s0 - 4'd1;
        else begin
            s0 = 4'd9;
            if (s1 != 4'd0) s1 = s1 - 4'd1;
            else begin
                s1 = 4'd5;
                if (m0 != 4'd0) m0 = m0 - 4'd1;
                else begin
                    m0 = 4'd9;
                    m1 = m1 - 4'd1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // Countdown chain model: load has priority over the active-low enable.
    always @(posedge clk) begin
        if (load) cnt <= {in3, in2, in1, in0};
        else if (!enablen) cnt <= bcdDec(cnt);
    end

    assign time_zero = (cnt == 16'h0);

    function automatic logic [31:0] packDut();
        return {11'b0, in3, in2, in1, in0, load, enablen, cooking, alarm, busy};
    endfunction

    function automatic logic [31:0] packExp();
        return {11'b0, eD, eLoad, eEn, eCook, eAlarm, eBusy};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Drain one scoreboard entry per cycle, sampled away from the rising edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(tagQ.pop_front(), packDut(), expQ.pop_front());
        end
    end

    task automatic applyStimulus(input string tag, input logic kv, input logic [3:0] kc,
                                 input logic st, input logic sc, input logic tk);
        key_valid  = kv;
        key_code   = kc;
        start      = st;
        stop_clear = sc;
        tick_1hz   = tk;
        expQ.push_back(packExp());
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        key_code   = 4'd0;
        start      = 1'b0;
        stop_clear = 1'b0;
        tick_1hz   = 1'b0;
    endtask

    task automatic idle(input string tag);
        applyStimulus(tag, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [3:0] code);
        applyStimulus("key", 1'b1, code, 1'b0, 1'b0, 1'b0);
        if (code <= 4'd9) eD = {eD[11:0], code};
    endtask

    task automatic setIdleExp();
        eLoad = 1'b0; eEn = 1'b1; eCook = 1'b0; eAlarm = 1'b0; eBusy = 1'b0;
    endtask

    task automatic startRun(input string tag);
        applyStimulus(tag, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        eLoad = 1'b1; eCook = 1'b1; eBusy = 1'b1;
        idle("load_cycle");
        eLoad = 1'b0;
        idle("run_first");
    endtask

    task automatic tickDown(input int n);
        for (int i = 0; i < n; i++) begin
            eEn = 1'b0;
            applyStimulus("tick_en", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            eEn = 1'b1;
            idle("tick_gap");
        end
    endtask

    task automatic expire();
        eEn = 1'b1;
        applyStimulus("expire_tick", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        eCook = 1'b0; eAlarm = 1'b1;
        idle("alarm_on");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset state, checked while reset is held.
        #1;
        checkOutput("reset_state", packDut(), packExp());
        @(posedge clk);
        #1;
        idle("reset_hold");
        rst = 1'b1;
        idle("post_reset");

        // Entry shifting and ignored codes.
        key(4'd1); key(4'd2); key(4'd3); key(4'd0);
        key(4'd11);
        key(4'd5);
        idle("entry_2305");
        applyStimulus("clear_idle", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        eD = 16'h0;
        idle("cleared");

        // Three-second cook, expiry and beeping.
        key(4'd0); key(4'd0); key(4'd0); key(4'd3);
        startRun("start_3s");
        tickDown(3);
        expire();
        for (int b = 0; b < BEEP; b++) begin
            applyStimulus("beep_tick", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
            if (b == BEEP - 1) begin
                eD = 16'h0;
                setIdleExp();
            end
            idle("beep_gap");
        end

        // 95 seconds entered with a seconds-tens digit of 9; stop during alarm.
        key(4'd0); key(4'd0); key(4'd9); key(4'd5);
        startRun("start_95s");
        tickDown(95);
        expire();
        applyStimulus("alarm_stop", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        eD = 16'h0;
        setIdleExp();
        idle("alarm_stopped");

        // Pause on a tick/stop tie, resume without load, clear from pause.
        key(4'd0); key(4'd0); key(4'd2); key(4'd0);
        startRun("start_20s");
        tickDown(1);
        eEn = 1'b1;
        applyStimulus("stop_tick_tie", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        eCook = 1'b0;
        applyStimulus("pause_tick", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus("resume", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        eCook = 1'b1;
        eEn = 1'b0;
        applyStimulus("resume_tick", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        eEn = 1'b1;
        applyStimulus("pause_again", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        eCook = 1'b0;
        applyStimulus("pause_to_idle", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        eD = 16'h0;
        eLoad = 1'b1;
        eBusy = 1'b0;
        idle("clear_load");
        eLoad = 1'b0;
        idle("idle_after_clear");

        // Start with an empty entry, then start+stop tie in IDLE.
        applyStimulus("start_zero", 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        idle("still_idle");
        key(4'd0); key(4'd0); key(4'd1); key(4'd0);
        applyStimulus("start_stop_tie", 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        eD = 16'h0;
        idle("tie_cleared");

        // Asynchronous reset in the middle of a run.
        key(4'd0); key(4'd0); key(4'd0); key(4'd5);
        startRun("start_5s");
        tickDown(1);
        tick_1hz = 1'b1;
        rst = 1'b0;
        eD = 16'h0;
        setIdleExp();
        #1;
        checkOutput("reset_mid_run", packDut(), packExp());
        tick_1hz = 1'b0;
        idle("reset_run_hold");
        rst = 1'b1;
        key(4'd7);
        idle("key_after_reset");

        // Asynchronous reset while the alarm is sounding.
        applyStimulus("clear_7", 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        eD = 16'h0;
        key(4'd1);
        startRun("start_1s");
        tickDown(1);
        expire();
        rst = 1'b0;
        eD = 16'h0;
        setIdleExp();
        #1;
        checkOutput("reset_mid_alarm", packDut(), packExp());
        idle("reset_alarm_hold");
        rst = 1'b1;
        key(4'd4);
        idle("key_after_reset2");

        @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
